// File: rtl/bcd_updown_counter_n.sv
// Cascaded N-decade BCD up/down counter with load, terminal count and wrap pulse.
// Optional multiplexed 7-segment scan driver enabled by macro BCD_SCAN_DISPLAY_EN.
module bcd_updown_counter_n #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  carry_out,
  output logic                  load_err,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_up, cnt_dn;
  logic         all9, all0, load_ok;
  logic         c_up, c_dn;
  logic [3:0]   d;

  // Ripple the carry/borrow enable through the decades: a digit steps only
  // when every lower digit sits at its wrap value.
  always_comb begin
    cnt_up  = '0;
    cnt_dn  = '0;
    load_ok = 1'b1;
    c_up    = 1'b1;
    c_dn    = 1'b1;
    d       = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d = count[4*k +: 4];
      cnt_up[4*k +: 4] = c_up ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
      cnt_dn[4*k +: 4] = c_dn ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
      c_up = c_up & (d == 4'd9);
      c_dn = c_dn & (d == 4'd0);
      if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
    end
    all9 = c_up;
    all0 = c_dn;
  end

  assign tc = en & (up ? all9 : all0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_ok) count    <= load_val;
        else         load_err <= 1'b1;
      end else if (en) begin
        count     <= up ? cnt_up : cnt_dn;
        carry_out <= up ? all9 : all0;
      end
    end
  end

`ifdef BCD_SCAN_DISPLAY_EN
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [15:0]   psc;
  logic [IW-1:0] idx;
  logic [3:0]    cur;
  logic [6:0]    seg_nxt;

  always_comb begin
    cur = count[4*int'(idx) +: 4];
    case (cur)
      4'd0:    seg_nxt = 7'b1111110;
      4'd1:    seg_nxt = 7'b0110000;
      4'd2:    seg_nxt = 7'b1101101;
      4'd3:    seg_nxt = 7'b1111001;
      4'd4:    seg_nxt = 7'b0110011;
      4'd5:    seg_nxt = 7'b1011011;
      4'd6:    seg_nxt = 7'b1011111;
      4'd7:    seg_nxt = 7'b1110000;
      4'd8:    seg_nxt = 7'b1111111;
      4'd9:    seg_nxt = 7'b1111011;
      default: seg_nxt = 7'b0000001;
    endcase
  end

  // Reset preloads the display with digit 0 showing "0" so it is valid immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      psc     <= '0;
      idx     <= '0;
      seg     <= 7'b1111110;
      dig_sel <= DIGITS'(1);
    end else begin
      seg     <= seg_nxt;
      dig_sel <= DIGITS'(1) << idx;
      if (psc == 16'(SCAN_DIV - 1)) begin
        psc <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        psc <= psc + 16'd1;
      end
    end
  end
`else
  assign seg     = '0;
  assign dig_sel = '0;
`endif

endmodule
